dest_reg_ctrl: RTL and testbench
================================

# dest_reg_ctrl

- Control and hazard block for the register-destination path of the five-stage MIPS pipeline.
- Decodes the ID-stage opcode to drive the select of the 5-bit destination mux (`rt` vs `rd`), then captures the muxed destination back from that mux.
- Carries the destination and its write/read flags through ID/EX, EX/MEM and MEM/WB.
- Generates the load-use stall and the EX-stage forwarding selects for the register file and ALU input muxes.

## Interface
Parameters:
- OPW, 6, opcode width
- RW, 5, register-index width (matches the destination mux)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- id_valid  in  1  ID stage holds a real instruction
- id_opcode  in  OPW  instruction[31:26]
- id_rs  in  RW  instruction[25:21]
- id_rt  in  RW  instruction[20:16]
- id_dest  in  RW  output of the 5-bit destination mux (a=rt, b=rd)
- flush  in  1  branch/jump taken; squash the ID instruction
- regdst_sel  out  1  destination mux select; 1 picks b (rd), 0 picks a (rt)
- stall  out  1  load-use stall; hold PC and IF/ID
- ex_dest, mem_dest, wb_dest  out  RW each  destination register per stage
- ex_regwrite, mem_regwrite, wb_regwrite  out  1 each  write-enable per stage
- ex_memread  out  1  EX instruction is a load
- fwd_a, fwd_b  out  2 each  ALU operand source for EX rs/rt: 00 regfile, 10 EX/MEM, 01 MEM/WB

## Operation
Decode (combinational on id_opcode):
- 000000 R-type: sel=1, regwrite=1, uses_rt=1.
- 100011 lw: sel=0, regwrite=1, memread=1.
- 001000 / 001010 / 001100 / 001101 (addi, slti, andi, ori): sel=0, regwrite=1.
- 101011 sw: regwrite=0, uses_rt=1.
- 000100 beq: regwrite=0, uses_rt=1.
- 000010 j: regwrite=0.
- Any other opcode: sel=0, regwrite=0, memread=0.
- regwrite is forced to 0 when id_dest==0 (writes to $0 never propagate).

Load-use hazard:
- stall = id_valid & ex_memread & (ex_dest!=0) & (ex_dest==id_rs | (uses_rt & ex_dest==id_rt)).

ID/EX register:
- Loads decoded flags, id_dest, id_rs and id_rt each cycle.
- Loads a bubble (regwrite=0, memread=0, dest=0) when stall | flush | !id_valid.
- stall and flush together produce a single bubble.

EX/MEM and MEM/WB:
- Always advance; never stalled or flushed by this block.

Forwarding:
- fwd_a=10 when mem_regwrite & mem_dest==ex_rs.
- Otherwise fwd_a=01 when wb_regwrite & wb_dest==ex_rs.
- Otherwise fwd_a=00.
- fwd_b uses the same rules against ex_rt.
- EX/MEM has priority when both stages match.
- mem_dest/wb_dest of 0 never match, because regwrite is already 0.

## Timing
- Pipeline registers update only on rising clk.
- regdst_sel and stall are combinational from ID inputs and ID/EX state; they are valid within the same cycle.
- fwd_a/fwd_b are combinational from registered state only.
- Latency: a decoded instruction reaches ex_* 1 cycle after ID, mem_* after 2, wb_* after 3.
- A stall lasts exactly 1 cycle per load: the bubble clears ex_memread, so stall drops the next cycle.
- Reset: rst_n low at a clock edge clears every pipeline register (all dest/flag outputs 0, fwd_a=fwd_b=00, stall=0 from the following cycle).
- Reset mid-operation discards all in-flight instructions; no partial writes survive.
- regdst_sel ignores reset, since it is purely combinational.

## Test plan
- Reset: rst_n=0 for 2 cycles with random inputs -> all ex/mem/wb outputs 0, stall=0, fwd=00; after release, add $3,$1,$2 (rd=3) -> regdst_sel=1, ex_dest=3 next cycle, wb_dest=3 three cycles later with wb_regwrite=1.
- Decode sweep: lw, addi, sw, beq, j, opcode 111111 -> regdst_sel 0,0,0,0,0,0; ex_regwrite 1,1,0,0,0,0; ex_memread only for lw.
- Load-use: lw $5 then add $6,$5,$1 -> stall=1 for exactly one cycle, a bubble in ex (ex_regwrite=0), then add enters EX with fwd_a=01. Repeat with add $6,$1,$5 -> fwd_b=01.
- No false stall: lw $5 then addi $7,$6,1 with rt=5 (rt is a destination, not a source) -> stall=0.
- Forward priority: add $4 then add $4 then add $8,$4,$4 -> fwd_a=fwd_b=10 (newest wins). Destination $0 in the producer -> fwd stays 00.
- Flush+stall: assert flush in the same cycle as a load-use stall -> one bubble only; reset asserted mid-stream -> all stages 0 next cycle.

Source files
------------

// File: rtl/dest_reg_ctrl.sv
// dest_reg_ctrl: rt/rd destination select, destination tracking through
// ID/EX, EX/MEM and MEM/WB, load-use stall and EX forwarding selects.
module dest_reg_ctrl #(
  parameter int OPW = 6,
  parameter int RW  = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           id_valid,
  input  logic [OPW-1:0] id_opcode,
  input  logic [RW-1:0]  id_rs,
  input  logic [RW-1:0]  id_rt,
  input  logic [RW-1:0]  id_dest,
  input  logic           flush,
  output logic           regdst_sel,
  output logic           stall,
  output logic [RW-1:0]  ex_dest,
  output logic [RW-1:0]  mem_dest,
  output logic [RW-1:0]  wb_dest,
  output logic           ex_regwrite,
  output logic           mem_regwrite,
  output logic           wb_regwrite,
  output logic           ex_memread,
  output logic [1:0]     fwd_a,
  output logic [1:0]     fwd_b
);
  localparam logic [OPW-1:0] OP_R    = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_LW   = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(6'b001000);
  localparam logic [OPW-1:0] OP_SLTI = OPW'(6'b001010);
  localparam logic [OPW-1:0] OP_ANDI = OPW'(6'b001100);
  localparam logic [OPW-1:0] OP_ORI  = OPW'(6'b001101);
  localparam logic [OPW-1:0] OP_SW   = OPW'(6'b101011);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'b000100);

  typedef struct packed {
    logic          regwrite;
    logic          memread;
    logic [RW-1:0] dest;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
  } id_ex_t;

  logic   dec_sel;
  logic   dec_regwrite;
  logic   dec_memread;
  logic   dec_uses_rt;
  logic   ex_hit;
  logic   bubble;
  id_ex_t id_ex;
  id_ex_t id_ex_d;

  always_comb begin
    dec_sel      = 1'b0;
    dec_regwrite = 1'b0;
    dec_memread  = 1'b0;
    dec_uses_rt  = 1'b0;
    unique case (1'b1)
      (id_opcode == OP_R): begin
        dec_sel      = 1'b1;
        dec_regwrite = 1'b1;
        dec_uses_rt  = 1'b1;
      end
      (id_opcode == OP_LW): begin
        dec_regwrite = 1'b1;
        dec_memread  = 1'b1;
      end
      (id_opcode == OP_ADDI) || (id_opcode == OP_SLTI) ||
      (id_opcode == OP_ANDI) || (id_opcode == OP_ORI):
        dec_regwrite = 1'b1;
      (id_opcode == OP_SW) || (id_opcode == OP_BEQ):
        dec_uses_rt = 1'b1;
      default: ;
    endcase
  end

  assign regdst_sel = dec_sel;

  assign ex_hit = (id_ex.dest == id_rs) ||
                  (dec_uses_rt && (id_ex.dest == id_rt));
  assign stall  = id_valid && id_ex.memread &&
                  (id_ex.dest != '0) && ex_hit;
  assign bubble = stall || flush || !id_valid;

  // A bubble is a full nop: no write, no load, all register fields $0.
  always_comb begin
    id_ex_d = '0;
    if (!bubble) begin
      id_ex_d.regwrite = dec_regwrite && (id_dest != '0);
      id_ex_d.memread  = dec_memread;
      id_ex_d.dest     = id_dest;
      id_ex_d.rs       = id_rs;
      id_ex_d.rt       = id_rt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_ex        <= '0;
      mem_dest     <= '0;
      mem_regwrite <= 1'b0;
      wb_dest      <= '0;
      wb_regwrite  <= 1'b0;
    end else begin
      id_ex        <= id_ex_d;
      mem_dest     <= id_ex.dest;
      mem_regwrite <= id_ex.regwrite;
      wb_dest      <= mem_dest;
      wb_regwrite  <= mem_regwrite;
    end
  end

  assign ex_dest     = id_ex.dest;
  assign ex_regwrite = id_ex.regwrite;
  assign ex_memread  = id_ex.memread;

  // EX/MEM holds the newer result, so it wins over MEM/WB.
  always_comb begin
    fwd_a = 2'b00;
    if (mem_regwrite && (mem_dest == id_ex.rs))
      fwd_a = 2'b10;
    else if (wb_regwrite && (wb_dest == id_ex.rs))
      fwd_a = 2'b01;
  end

  always_comb begin
    fwd_b = 2'b00;
    if (mem_regwrite && (mem_dest == id_ex.rt))
      fwd_b = 2'b10;
    else if (wb_regwrite && (wb_dest == id_ex.rt))
      fwd_b = 2'b01;
  end

endmodule

// File: tb/tb_dest_reg_ctrl.sv
// tb_dest_reg_ctrl: decode table, directed hazard sequences and random
// traffic against an instruction-level pipeline model.
module tb_dest_reg_ctrl;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [5:0] id_opcode;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic [4:0] id_dest;
  logic       flush;
  logic       regdst_sel;
  logic       stall;
  logic [4:0] ex_dest;
  logic [4:0] mem_dest;
  logic [4:0] wb_dest;
  logic       ex_regwrite;
  logic       mem_regwrite;
  logic       wb_regwrite;
  logic       ex_memread;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  int checks   = 0;
  int failures = 0;

  dest_reg_ctrl #(.OPW(6), .RW(5)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
    .id_dest(id_dest), .flush(flush), .regdst_sel(regdst_sel),
    .stall(stall), .ex_dest(ex_dest), .mem_dest(mem_dest),
    .wb_dest(wb_dest), .ex_regwrite(ex_regwrite),
    .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
    .ex_memread(ex_memread), .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       sel;
    logic       we;
    logic       mr;
  } dvec_t;

  typedef struct {
    logic       we;
    logic       mr;
    logic [4:0] dest;
    logic [4:0] rs;
    logic [4:0] rt;
  } rec_t;

  dvec_t      tbl [11];
  logic [5:0] ops [11];
  rec_t       m_ex, m_mem, m_wb;
  rec_t       nop_rec;

  // {sel, regwrite, memread, uses_rt} straight from the opcode table
  function automatic logic [3:0] spec_decode(logic [5:0] op);
    case (op)
      OP_R:    return 4'b1101;
      OP_LW:   return 4'b0110;
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: return 4'b0100;
      OP_SW, OP_BEQ: return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [1:0] exp_fwd(logic [4:0] src);
    if (m_mem.we && m_mem.dest == src) return 2'b10;
    if (m_wb.we && m_wb.dest == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic ck();
    @(posedge clk);
    #1;
  endtask

  task automatic ins(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                     logic [4:0] rd, logic fl);
    logic [3:0] d;
    d = spec_decode(op);
    id_valid  = 1'b1;
    id_opcode = op;
    id_rs     = rs;
    id_rt     = rt;
    id_dest   = d[3] ? rd : rt;
    flush     = fl;
    #1;
  endtask

  task automatic nop();
    id_valid  = 1'b0;
    id_opcode = 6'd0;
    id_rs     = 5'd0;
    id_rt     = 5'd0;
    id_dest   = 5'd0;
    flush     = 1'b0;
    #1;
  endtask

  task automatic drain();
    repeat (3) begin
      nop();
      ck();
    end
  endtask

  function automatic logic [24:0] all_outs();
    return {regdst_sel, stall, ex_dest, ex_regwrite, ex_memread,
            mem_dest, mem_regwrite, wb_dest, wb_regwrite, fwd_a, fwd_b};
  endfunction

  initial begin
    tbl[0]  = '{OP_R,    5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0};
    tbl[1]  = '{OP_R,    5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{OP_LW,   5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1};
    tbl[3]  = '{OP_ADDI, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{OP_SLTI, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{OP_ANDI, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{OP_ORI,  5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{OP_SW,   5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{OP_BEQ,  5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{OP_J,    5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{OP_BAD,  5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0};
    ops = '{OP_R, OP_LW, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI,
            OP_SW, OP_BEQ, OP_J, OP_BAD, OP_LW};
    nop_rec = '{1'b0, 1'b0, 5'd0, 5'd0, 5'd0};

    // reset with garbage on the ID inputs
    rst_n     = 1'b0;
    id_valid  = 1'b1;
    flush     = 1'b0;
    id_opcode = OP_LW;
    id_rs     = 5'($urandom);
    id_rt     = 5'($urandom);
    id_dest   = 5'($urandom);
    ck();
    id_opcode = 6'($urandom);
    id_rs     = 5'($urandom);
    id_dest   = 5'($urandom);
    ck();
    chk("reset_ex", 32'({ex_dest, ex_regwrite, ex_memread}), 32'd0);
    chk("reset_mem", 32'({mem_dest, mem_regwrite}), 32'd0);
    chk("reset_wb", 32'({wb_dest, wb_regwrite}), 32'd0);
    chk("reset_fwd_stall", 32'({fwd_a, fwd_b, stall}), 32'd0);

    rst_n = 1'b1;
    ins(OP_R, 5'd1, 5'd2, 5'd3, 1'b0);
    chk("add_sel", 32'(regdst_sel), 32'd1);
    ck();
    chk("add_ex", 32'({ex_dest, ex_regwrite}), 32'({5'd3, 1'b1}));
    nop();
    ck();
    ck();
    chk("add_wb", 32'({wb_dest, wb_regwrite}), 32'({5'd3, 1'b1}));

    // decode table
    for (int i = 0; i < 11; i++) begin
      ins(tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].rd, 1'b0);
      chk($sformatf("dec%0d_sel", i), 32'(regdst_sel), 32'(tbl[i].sel));
      chk($sformatf("dec%0d_stall", i), 32'(stall), 32'd0);
      ck();
      chk($sformatf("dec%0d_ex", i),
          32'({ex_dest, ex_regwrite, ex_memread}),
          32'({tbl[i].sel ? tbl[i].rd : tbl[i].rt, tbl[i].we, tbl[i].mr}));
    end

    // load-use on rs
    drain();
    ins(OP_LW, 5'd1, 5'd5, 5'd0, 1'b0);
    ck();
    ins(OP_R, 5'd5, 5'd1, 5'd6, 1'b0);
    chk("lu_a_stall", 32'(stall), 32'd1);
    ck();
    chk("lu_a_bubble", 32'({ex_regwrite, ex_memread, ex_dest}), 32'd0);
    chk("lu_a_stall_drop", 32'(stall), 32'd0);
    ck();
    chk("lu_a_ex", 32'({ex_dest, ex_regwrite}), 32'({5'd6, 1'b1}));
    chk("lu_a_fwd", 32'({fwd_a, fwd_b}), 32'({2'b01, 2'b00}));

    // load-use on rt
    drain();
    ins(OP_LW, 5'd1, 5'd5, 5'd0, 1'b0);
    ck();
    ins(OP_R, 5'd1, 5'd5, 5'd6, 1'b0);
    chk("lu_b_stall", 32'(stall), 32'd1);
    ck();
    chk("lu_b_stall_drop", 32'(stall), 32'd0);
    ck();
    chk("lu_b_fwd", 32'({fwd_a, fwd_b}), 32'({2'b00, 2'b01}));

    // rt of an I-type is a destination, not a source
    drain();
    ins(OP_LW, 5'd1, 5'd5, 5'd0, 1'b0);
    ck();
    ins(OP_ADDI, 5'd6, 5'd5, 5'd0, 1'b0);
    chk("no_false_stall", 32'(stall), 32'd0);

    // newest producer wins
    drain();
    ins(OP_R, 5'd1, 5'd2, 5'd4, 1'b0);
    ck();
    ins(OP_R, 5'd1, 5'd2, 5'd4, 1'b0);
    ck();
    ins(OP_R, 5'd4, 5'd4, 5'd8, 1'b0);
    ck();
    chk("fwd_priority", 32'({fwd_a, fwd_b}), 32'({2'b10, 2'b10}));

    // $0 producer never forwards
    drain();
    ins(OP_R, 5'd1, 5'd2, 5'd0, 1'b0);
    ck();
    ins(OP_R, 5'd0, 5'd0, 5'd9, 1'b0);
    ck();
    chk("fwd_zero_mem", 32'({fwd_a, fwd_b}), 32'd0);
    nop();
    ck();
    chk("fwd_zero_wb_regwrite", 32'(wb_regwrite), 32'd0);

    // flush and stall together: a single bubble
    drain();
    ins(OP_LW, 5'd1, 5'd5, 5'd0, 1'b0);
    ck();
    ins(OP_R, 5'd5, 5'd1, 5'd6, 1'b1);
    chk("fs_stall", 32'(stall), 32'd1);
    ck();
    chk("fs_bubble", 32'({ex_regwrite, ex_dest}), 32'd0);
    ins(OP_R, 5'd1, 5'd2, 5'd7, 1'b0);
    chk("fs_no_second_stall", 32'(stall), 32'd0);
    ck();
    chk("fs_next", 32'({ex_dest, ex_regwrite}), 32'({5'd7, 1'b1}));

    // reset mid-stream
    ins(OP_R, 5'd1, 5'd2, 5'd4, 1'b0);
    ck();
    ins(OP_LW, 5'd1, 5'd9, 5'd0, 1'b0);
    ck();
    ins(OP_R, 5'd9, 5'd2, 5'd5, 1'b0);
    chk("mid_full", 32'({wb_regwrite, mem_regwrite, ex_memread}), 32'd7);
    rst_n = 1'b0;
    ck();
    chk("mid_reset", 32'(all_outs()), 32'({1'b1, 24'd0}));
    rst_n = 1'b1;

    // random traffic against the model
    m_ex  = nop_rec;
    m_mem = nop_rec;
    m_wb  = nop_rec;
    for (int i = 0; i < 500; i++) begin
      logic [3:0]  d;
      logic [4:0]  rd;
      logic        st;
      logic [24:0] exp;
      rst_n    = ($urandom_range(0, 49) != 0);
      id_valid = ($urandom_range(0, 9) != 0);
      flush    = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 11) == 0)
        id_opcode = 6'($urandom);
      else
        id_opcode = ops[$urandom_range(0, 10)];
      id_rs   = 5'($urandom_range(0, 7));
      id_rt   = 5'($urandom_range(0, 7));
      rd      = 5'($urandom_range(0, 7));
      d       = spec_decode(id_opcode);
      id_dest = d[3] ? rd : id_rt;
      #1;
      st = id_valid && m_ex.mr && (m_ex.dest != 5'd0) &&
           ((m_ex.dest == id_rs) || (d[0] && m_ex.dest == id_rt));
      exp = {d[3], st, m_ex.dest, m_ex.we, m_ex.mr, m_mem.dest,
             m_mem.we, m_wb.dest, m_wb.we, exp_fwd(m_ex.rs),
             exp_fwd(m_ex.rt)};
      chk($sformatf("rand%0d", i), 32'(all_outs()), 32'(exp));
      if (!rst_n) begin
        m_ex  = nop_rec;
        m_mem = nop_rec;
        m_wb  = nop_rec;
      end else begin
        m_wb  = m_mem;
        m_mem = m_ex;
        if (st || flush || !id_valid)
          m_ex = nop_rec;
        else
          m_ex = '{d[2] && (id_dest != 5'd0), d[1], id_dest, id_rs, id_rt};
      end
      ck();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
